// File: rtl/mpt_pkg.sv
// Shared types and defaults for the issue-stage transaction tracker.
package mpt_pkg;

  localparam int unsigned MPT_NUM_TXN    = 4;
  localparam int unsigned MPT_DATA_WIDTH = 32;
  localparam int unsigned MPT_ID_WIDTH   = $clog2(MPT_NUM_TXN);

  typedef logic [MPT_ID_WIDTH-1:0] txn_id_t;

  typedef struct packed {
    logic [MPT_DATA_WIDTH-1:0] payload;
  } txn_entry_t;

endpackage

// File: rtl/free_id_finder.sv
// Combinational lowest-zero priority encoder over the busy vector.
module free_id_finder #(
  parameter int unsigned NUM_TXN = 4,
  localparam int unsigned ID_WIDTH = $clog2(NUM_TXN)
) (
  input  logic [NUM_TXN-1:0]  busy,
  output logic [ID_WIDTH-1:0] id,
  output logic                any_free
);

  assign any_free = ~&busy;

  // Scan high to low so the last hit, the lowest free index, wins.
  always_comb begin
    id = '0;
    for (int i = NUM_TXN - 1; i >= 0; i--) begin
      if (!busy[i]) id = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/issue_txn_tracker.sv
// Allocates transaction IDs to fetch requests, tracks them while outstanding and
// pairs backend replies with the stored payload for the PLB lookup.
module issue_txn_tracker
  import mpt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MPT_DATA_WIDTH,
  parameter int unsigned NUM_TXN    = MPT_NUM_TXN,
  localparam int unsigned ID_WIDTH  = $clog2(NUM_TXN)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  iss_valid_o,
  input  logic                  iss_ready_i,
  output logic [DATA_WIDTH-1:0] iss_data_o,
  output logic [ID_WIDTH-1:0]   iss_id_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [ID_WIDTH-1:0]   rsp_id_i,
  output logic                  lkp_valid_o,
  input  logic                  lkp_ready_i,
  output logic [DATA_WIDTH-1:0] lkp_data_o,
  output logic [ID_WIDTH-1:0]   lkp_id_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic [ID_WIDTH:0]     outstanding_o,
  output logic                  spurious_o
);

  logic [NUM_TXN-1:0]    busy_q, busy_d;
  logic [DATA_WIDTH-1:0] entry_q [NUM_TXN];
  logic [ID_WIDTH-1:0]   alloc_id;
  logic                  free_any;
  logic                  accept, rsp_hs, rsp_hit;
  logic [ID_WIDTH:0]     outstanding_q, outstanding_d;

  logic                  iss_valid_q;
  logic [DATA_WIDTH-1:0] iss_data_q;
  logic [ID_WIDTH-1:0]   iss_id_q;
  logic                  lkp_valid_q;
  logic [DATA_WIDTH-1:0] lkp_data_q;
  logic [ID_WIDTH-1:0]   lkp_id_q;
  logic                  spurious_q;

  free_id_finder #(
    .NUM_TXN (NUM_TXN)
  ) u_free_id_finder (
    .busy     (busy_q),
    .id       (alloc_id),
    .any_free (free_any)
  );

  assign req_ready_o = free_any & (~iss_valid_q | iss_ready_i) & ~flush_i;
  assign rsp_ready_o = (~lkp_valid_q | lkp_ready_i) & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_hs      = rsp_valid_i & rsp_ready_o;
  assign rsp_hit     = rsp_hs & busy_q[rsp_id_i];

  // alloc_id is always free and rsp_id_i is busy on a hit, so the two never collide.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (rsp_hit) busy_d[rsp_id_i] = 1'b0;
      if (accept)  busy_d[alloc_id] = 1'b1;
    end
  end

  always_comb begin
    outstanding_d = '0;
    for (int unsigned i = 0; i < NUM_TXN; i++) begin
      outstanding_d = outstanding_d + (ID_WIDTH + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      spurious_q    <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      spurious_q    <= rsp_hs & ~busy_q[rsp_id_i];
    end
  end

  // Payloads are only read back for busy slots, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) entry_q[alloc_id] <= req_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_valid_q <= 1'b0;
      iss_data_q  <= '0;
      iss_id_q    <= '0;
    end else if (flush_i) begin
      iss_valid_q <= 1'b0;
    end else if (accept) begin
      iss_valid_q <= 1'b1;
      iss_data_q  <= req_data_i;
      iss_id_q    <= alloc_id;
    end else if (iss_ready_i) begin
      iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lkp_valid_q <= 1'b0;
      lkp_data_q  <= '0;
      lkp_id_q    <= '0;
    end else if (flush_i) begin
      lkp_valid_q <= 1'b0;
    end else if (rsp_hit) begin
      lkp_valid_q <= 1'b1;
      lkp_data_q  <= entry_q[rsp_id_i];
      lkp_id_q    <= rsp_id_i;
    end else if (lkp_ready_i) begin
      lkp_valid_q <= 1'b0;
    end
  end

  assign iss_valid_o   = iss_valid_q;
  assign iss_data_o    = iss_data_q;
  assign iss_id_o      = iss_id_q;
  assign lkp_valid_o   = lkp_valid_q;
  assign lkp_data_o    = lkp_data_q;
  assign lkp_id_o      = lkp_id_q;
  assign outstanding_o = outstanding_q;
  assign busy_o        = |busy_q;
  assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_issue_txn_tracker.sv
// Directed, table-driven bench for issue_txn_tracker with NUM_TXN=4.
module tb_issue_txn_tracker;

  logic        clk, rst_ni;
  logic        req_valid, req_ready, iss_valid, iss_ready, rsp_valid, rsp_ready;
  logic        lkp_valid, lkp_ready, flush, busy, spurious;
  logic [31:0] req_data, iss_data, lkp_data;
  logic [1:0]  iss_id, rsp_id, lkp_id;
  logic [2:0]  outstanding;

  int tests = 0;
  int fails = 0;

  issue_txn_tracker #(
    .DATA_WIDTH (32),
    .NUM_TXN    (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .iss_valid_o   (iss_valid),
    .iss_ready_i   (iss_ready),
    .iss_data_o    (iss_data),
    .iss_id_o      (iss_id),
    .rsp_valid_i   (rsp_valid),
    .rsp_ready_o   (rsp_ready),
    .rsp_id_i      (rsp_id),
    .lkp_valid_o   (lkp_valid),
    .lkp_ready_i   (lkp_ready),
    .lkp_data_o    (lkp_data),
    .lkp_id_o      (lkp_id),
    .flush_i       (flush),
    .busy_o        (busy),
    .outstanding_o (outstanding),
    .spurious_o    (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rv; logic [31:0] rd; logic ir; logic sv; logic [1:0] sid; logic lr; logic fl;
    logic e_rqr; logic e_rsr;
    logic e_iv; logic [1:0] e_iid; logic [31:0] e_idat;
    logic e_lv; logic [1:0] e_lid; logic [31:0] e_ldat;
    logic [2:0] e_out; logic e_sp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] d(input int i);
    return 32'hCAFE_0000 + 32'(i);
  endfunction

  task automatic add(input logic rv, input logic [31:0] rd, input logic ir, input logic sv,
                     input logic [1:0] sid, input logic lr, input logic fl,
                     input logic rqr, input logic rsr,
                     input logic iv, input logic [1:0] iid, input logic [31:0] idat,
                     input logic lv, input logic [1:0] lid, input logic [31:0] ldat,
                     input logic [2:0] out, input logic sp);
    vec_t v;
    v.rv = rv; v.rd = rd; v.ir = ir; v.sv = sv; v.sid = sid; v.lr = lr; v.fl = fl;
    v.e_rqr = rqr; v.e_rsr = rsr;
    v.e_iv = iv; v.e_iid = iid; v.e_idat = idat;
    v.e_lv = lv; v.e_lid = lid; v.e_ldat = ldat;
    v.e_out = out; v.e_sp = sp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_post(input string tag, input vec_t v);
    chk({tag, " iss_valid"}, 32'(iss_valid), 32'(v.e_iv));
    chk({tag, " iss_id"}, 32'(iss_id), 32'(v.e_iid));
    chk({tag, " iss_data"}, iss_data, v.e_idat);
    chk({tag, " lkp_valid"}, 32'(lkp_valid), 32'(v.e_lv));
    chk({tag, " lkp_id"}, 32'(lkp_id), 32'(v.e_lid));
    chk({tag, " lkp_data"}, lkp_data, v.e_ldat);
    chk({tag, " outstanding"}, 32'(outstanding), 32'(v.e_out));
    chk({tag, " busy"}, 32'(busy), 32'(v.e_out != 3'd0));
    chk({tag, " spurious"}, 32'(spurious), 32'(v.e_sp));
  endtask

  initial begin
    vec_t z;
    // Back-to-back fill: IDs 0..3, then throttled.
    add(1, d(0), 1, 0, 0, 1, 0,  1, 1,  1, 0, d(0),  0, 0, 0,     1, 0);
    add(1, d(1), 1, 0, 0, 1, 0,  1, 1,  1, 1, d(1),  0, 0, 0,     2, 0);
    add(1, d(2), 1, 0, 0, 1, 0,  1, 1,  1, 2, d(2),  0, 0, 0,     3, 0);
    add(1, d(3), 1, 0, 0, 1, 0,  1, 1,  1, 3, d(3),  0, 0, 0,     4, 0);
    add(1, d(9), 1, 0, 0, 1, 0,  0, 1,  0, 3, d(3),  0, 0, 0,     4, 0);
    // Reply id 2 frees it; next request reuses id 2.
    add(0, 0,    1, 1, 2, 1, 0,  0, 1,  0, 3, d(3),  1, 2, d(2),  3, 0);
    add(1, d(4), 1, 0, 0, 1, 0,  1, 1,  1, 2, d(4),  0, 2, d(2),  4, 0);
    // Lookup back-pressure holding id 1 result.
    add(0, 0,    1, 1, 1, 0, 0,  0, 1,  0, 2, d(4),  1, 1, d(1),  3, 0);
    add(0, 0,    1, 1, 0, 0, 0,  1, 0,  0, 2, d(4),  1, 1, d(1),  3, 0);
    add(0, 0,    1, 1, 0, 0, 0,  1, 0,  0, 2, d(4),  1, 1, d(1),  3, 0);
    add(0, 0,    1, 0, 0, 1, 0,  1, 1,  0, 2, d(4),  0, 1, d(1),  3, 0);
    add(0, 0,    1, 1, 0, 1, 0,  1, 1,  0, 2, d(4),  1, 0, d(0),  2, 0);
    add(0, 0,    1, 0, 0, 1, 0,  1, 1,  0, 2, d(4),  0, 0, d(0),  2, 0);
    // Spurious reply to free id 1: one-cycle pulse, nothing else moves.
    add(0, 0,    1, 1, 1, 1, 0,  1, 1,  0, 2, d(4),  0, 0, d(0),  2, 1);
    add(0, 0,    1, 0, 0, 1, 0,  1, 1,  0, 2, d(4),  0, 0, d(0),  2, 0);
    // Simultaneous allocate and free of different IDs.
    add(1, d(5), 1, 1, 3, 1, 0,  1, 1,  1, 0, d(5),  1, 3, d(3),  2, 0);
    add(1, d(6), 1, 1, 0, 1, 0,  1, 1,  1, 1, d(6),  1, 0, d(5),  2, 0);
    add(1, d(7), 1, 0, 0, 1, 0,  1, 1,  1, 0, d(7),  0, 0, d(5),  3, 0);
    // Reply before the issue handshake completes.
    add(0, 0,    0, 1, 0, 1, 0,  0, 1,  1, 0, d(7),  1, 0, d(7),  2, 0);
    add(0, 0,    1, 0, 0, 1, 0,  1, 1,  0, 0, d(7),  0, 0, d(7),  2, 0);
    // Build 3 outstanding with both valids up, then flush.
    add(1, d(8), 1, 0, 0, 0, 0,  1, 1,  1, 0, d(8),  0, 0, d(7),  3, 0);
    add(1, d(9), 1, 1, 1, 0, 0,  1, 1,  1, 3, d(9),  1, 1, d(6),  3, 0);
    add(1, d(10), 0, 1, 2, 0, 1, 0, 0,  0, 3, d(9),  0, 1, d(6),  0, 0);
    add(0, 0,    1, 1, 0, 1, 0,  1, 1,  0, 3, d(9),  0, 1, d(6),  0, 1);
    add(0, 0,    1, 0, 0, 1, 0,  1, 1,  0, 3, d(9),  0, 1, d(6),  0, 0);
    add(1, d(10), 1, 0, 0, 1, 0, 1, 1,  1, 0, d(10), 0, 1, d(6),  1, 0);
    add(1, d(11), 1, 1, 0, 0, 0, 1, 1,  1, 1, d(11), 1, 0, d(10), 1, 0);

    rst_ni = 1'b0;
    req_valid = 0; req_data = 0; iss_ready = 0; rsp_valid = 0; rsp_id = 0;
    lkp_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    z = '{default: '0};
    z.e_rqr = 1'b1; z.e_rsr = 1'b1;
    chk_post("reset", z);
    chk("reset req_ready", 32'(req_ready), 32'(z.e_rqr));
    chk("reset rsp_ready", 32'(rsp_ready), 32'(z.e_rsr));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      req_valid = v.rv; req_data = v.rd; iss_ready = v.ir;
      rsp_valid = v.sv; rsp_id = v.sid; lkp_ready = v.lr; flush = v.fl;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.e_rqr));
      chk($sformatf("v%0d rsp_ready", i), 32'(rsp_ready), 32'(v.e_rsr));
      @(posedge clk);
      #1;
      chk_post($sformatf("v%0d", i), v);
    end

    // Asynchronous reset mid-traffic, checked before the next clock edge.
    req_valid = 0; rsp_valid = 0;
    #2;
    rst_ni = 1'b0;
    #1;
    z = '{default: '0};
    chk_post("async_rst", z);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
